// File: rtl/latch_mem_wr_sched_if.sv
// Bundled request, memory write-port and forwarding signals of the entry-memory write scheduler.
// The master side drives requests and the read address; the slave side is the scheduler.
interface latch_mem_wr_sched_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 8
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;

  logic                  we_a;
  logic [ADDR_WIDTH-1:0] waddr_a;
  logic [DATA_WIDTH-1:0] wdata_a;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] waddr_b;
  logic [DATA_WIDTH-1:0] wdata_b;

  logic [ADDR_WIDTH-1:0] fwd_raddr;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  logic [CNT_WIDTH-1:0]  drop_cnt;
  logic                  idle;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output fwd_raddr,
    input  req0_ready, req1_ready,
    input  we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b,
    input  fwd_hit, fwd_data, drop_cnt, idle
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  fwd_raddr,
    output req0_ready, req1_ready,
    output we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b,
    output fwd_hit, fwd_data, drop_cnt, idle
  );
endinterface

// File: rtl/latch_mem_wr_sched.sv
// Write scheduler in front of the latch-based entry memory: two buffered request streams,
// collision serialisation, illegal-address dropping and read-after-write forwarding.
module latch_mem_wr_sched #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_WORDS  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input logic                 clk_int,
  input logic                 rst_n,
  latch_mem_wr_sched_if.slave bus
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  wr_req_t fifo0_mem [FIFO_DEPTH];
  wr_req_t fifo1_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr0, rd_ptr0;
  logic [PTR_W-1:0] wr_ptr1, rd_ptr1;

  logic full0, empty0, full1, empty1;
  logic push0, push1, pop0, pop1;
  logic legal0, legal1, collide;
  logic issue_a, issue_b;
  logic [1:0] drop_inc;
  logic [CNT_WIDTH:0] drop_sum;

  wr_req_t head0, head1;

  logic                  we_a_q, we_b_q;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;

  logic                  sh_we_a, sh_we_b;
  logic [ADDR_WIDTH-1:0] sh_addr_a, sh_addr_b;
  logic [DATA_WIDTH-1:0] sh_data_a, sh_data_b;

  logic [CNT_WIDTH-1:0]  drop_cnt_q;
  logic                  fwd_hit_c;
  logic [DATA_WIDTH-1:0] fwd_data_c;

  // The wrap bit distinguishes full from empty when the index bits match.
  assign full0  = (wr_ptr0[PTR_W-1] != rd_ptr0[PTR_W-1]) &&
                  (wr_ptr0[IDX_W-1:0] == rd_ptr0[IDX_W-1:0]);
  assign empty0 = (wr_ptr0 == rd_ptr0);
  assign full1  = (wr_ptr1[PTR_W-1] != rd_ptr1[PTR_W-1]) &&
                  (wr_ptr1[IDX_W-1:0] == rd_ptr1[IDX_W-1:0]);
  assign empty1 = (wr_ptr1 == rd_ptr1);

  assign push0 = bus.req0_valid && !full0;
  assign push1 = bus.req1_valid && !full1;

  assign head0 = fifo0_mem[rd_ptr0[IDX_W-1:0]];
  assign head1 = fifo1_mem[rd_ptr1[IDX_W-1:0]];

  // Word 0 is hardwired zero; the upper bound only matters when the address space exceeds the array.
  if (NUM_WORDS < (1 << ADDR_WIDTH)) begin : g_range
    assign legal0 = (head0.addr != '0) && (head0.addr < ADDR_WIDTH'(NUM_WORDS));
    assign legal1 = (head1.addr != '0) && (head1.addr < ADDR_WIDTH'(NUM_WORDS));
  end else begin : g_no_range
    assign legal0 = (head0.addr != '0);
    assign legal1 = (head1.addr != '0);
  end

  always_comb begin
    collide  = 1'b0;
    pop0     = 1'b0;
    pop1     = 1'b0;
    issue_a  = 1'b0;
    issue_b  = 1'b0;
    drop_inc = 2'd0;
    // Same-address pair: B goes first so the stream 0 value lands last.
    collide  = !empty0 && !empty1 && legal0 && legal1 && (head0.addr == head1.addr);
    pop1     = !empty1;
    pop0     = !empty0 && !collide;
    issue_a  = pop0 && legal0;
    issue_b  = pop1 && legal1;
    drop_inc = {1'b0, pop0 && !legal0} + {1'b0, pop1 && !legal1};
  end

  assign drop_sum = {1'b0, drop_cnt_q} + (CNT_WIDTH + 1)'(drop_inc);

  always_ff @(posedge clk_int) begin
    if (push0) fifo0_mem[wr_ptr0[IDX_W-1:0]] <= {bus.req0_addr, bus.req0_data};
    if (push1) fifo1_mem[wr_ptr1[IDX_W-1:0]] <= {bus.req1_addr, bus.req1_data};
  end

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr0 <= '0;
      rd_ptr0 <= '0;
      wr_ptr1 <= '0;
      rd_ptr1 <= '0;
    end else begin
      if (push0) wr_ptr0 <= wr_ptr0 + PTR_W'(1);
      if (pop0)  rd_ptr0 <= rd_ptr0 + PTR_W'(1);
      if (push1) wr_ptr1 <= wr_ptr1 + PTR_W'(1);
      if (pop1)  rd_ptr1 <= rd_ptr1 + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      we_a_q    <= 1'b0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      we_b_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
    end else begin
      we_a_q <= issue_a;
      we_b_q <= issue_b;
      if (issue_a) begin
        waddr_a_q <= head0.addr;
        wdata_a_q <= head0.data;
      end
      if (issue_b) begin
        waddr_b_q <= head1.addr;
        wdata_b_q <= head1.data;
      end
    end
  end

  // The memory shows a write two cycles after its enable, so keep one more stage for forwarding.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      sh_we_a   <= 1'b0;
      sh_addr_a <= '0;
      sh_data_a <= '0;
      sh_we_b   <= 1'b0;
      sh_addr_b <= '0;
      sh_data_b <= '0;
    end else begin
      sh_we_a   <= we_a_q;
      sh_addr_a <= waddr_a_q;
      sh_data_a <= wdata_a_q;
      sh_we_b   <= we_b_q;
      sh_addr_b <= waddr_b_q;
      sh_data_b <= wdata_b_q;
    end
  end

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop_sum[CNT_WIDTH]) begin
      drop_cnt_q <= '1;
    end else begin
      drop_cnt_q <= drop_sum[CNT_WIDTH-1:0];
    end
  end

  // Newest write wins: output stage before shadow, and B before A within a stage.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    if (bus.fwd_raddr != '0) begin
      if (we_b_q && (waddr_b_q == bus.fwd_raddr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = wdata_b_q;
      end else if (we_a_q && (waddr_a_q == bus.fwd_raddr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = wdata_a_q;
      end else if (sh_we_b && (sh_addr_b == bus.fwd_raddr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = sh_data_b;
      end else if (sh_we_a && (sh_addr_a == bus.fwd_raddr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = sh_data_a;
      end
    end
  end

  assign bus.req0_ready = !full0;
  assign bus.req1_ready = !full1;
  assign bus.we_a       = we_a_q;
  assign bus.waddr_a    = waddr_a_q;
  assign bus.wdata_a    = wdata_a_q;
  assign bus.we_b       = we_b_q;
  assign bus.waddr_b    = waddr_b_q;
  assign bus.wdata_b    = wdata_b_q;
  assign bus.fwd_hit    = fwd_hit_c;
  assign bus.fwd_data   = fwd_data_c;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.idle       = empty0 && empty1 && !we_a_q && !we_b_q && !sh_we_a && !sh_we_b;

endmodule
